// File: rtl/mem_port_arbiter_if.sv
// Memory port arbiter bundle: IF/DM requests, memory ready and error clear in;
// mux select, valid, done pulses, stalls, busy and sticky timeout error out.
interface mem_port_arbiter_if;
  logic if_req;
  logic dm_req;
  logic mem_ready;
  logic err_clr;
  logic mem_sel;
  logic mem_valid;
  logic if_done;
  logic dm_done;
  logic if_stall;
  logic dm_stall;
  logic busy;
  logic timeout_err;

  modport master (
    input  if_req, dm_req, mem_ready, err_clr,
    output mem_sel, mem_valid, if_done, dm_done,
    output if_stall, dm_stall, busy, timeout_err
  );

  modport slave (
    output if_req, dm_req, mem_ready, err_clr,
    input  mem_sel, mem_valid, if_done, dm_done,
    input  if_stall, dm_stall, busy, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF and DM: holds the mux select for a whole
// transaction, aborts grants after TIMEOUT cycles, raises pipeline stalls.
// Ports: clk, reset_n (async low), bus (mem_port_arbiter_if.master).
// Option: MEM_ARB_STARVE_GUARD_EN lets a starved IF win over DM.
module mem_port_arbiter #(
  parameter int unsigned WAIT_LIMIT = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input logic             clk,
  input logic             reset_n,
  mem_port_arbiter_if.master bus
);

  if (WAIT_LIMIT < 1 || TIMEOUT < 2) begin : g_bad_param
    $error("mem_port_arbiter: WAIT_LIMIT>=1, TIMEOUT>=2");
  end

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IF = 2'd1,
    GRANT_DM = 2'd2
  } state_t;

  state_t        state;
  logic [TW-1:0] tcnt;
  logic          valid_q;
  logic          sel_q;
  logic          busy_q;
  logic          err_q;
  logic          granted;
  logic          last;
  logic          to_hit;
  logic          done;
  logic          guard;
  logic          dm_win;
  logic          if_win;

  // tcnt counts finished grant cycles, so the TIMEOUT-th cycle sees TIMEOUT-1
  assign granted = (state == GRANT_IF) || (state == GRANT_DM);
  assign last    = tcnt == TW'(TIMEOUT - 1);
  assign to_hit  = granted & ~bus.mem_ready & last;
  assign done    = granted & (bus.mem_ready | last);

  assign dm_win = bus.dm_req & ~(guard & bus.if_req);
  assign if_win = bus.if_req & ~dm_win;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned WW = $clog2(WAIT_LIMIT + 1);

  logic [WW-1:0] wcnt;
  logic          if_entry;

  assign if_entry = (state == IDLE) & if_win;
  assign guard    = wcnt >= WW'(WAIT_LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt <= '0;
    end else if (!bus.if_req || if_entry) begin
      wcnt <= '0;
    end else if (state != GRANT_IF &&
                 wcnt != WW'(WAIT_LIMIT)) begin
      wcnt <= wcnt + 1'b1;
    end
  end
`else
  assign guard = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      tcnt    <= '0;
      valid_q <= 1'b0;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          tcnt <= '0;
          unique case (1'b1)
            dm_win: begin
              state   <= GRANT_DM;
              sel_q   <= 1'b1;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
            end
            if_win: begin
              state   <= GRANT_IF;
              sel_q   <= 1'b0;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
            end
            default: ;
          endcase
        end
        GRANT_IF, GRANT_DM: begin
          if (done) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // a set on the same edge as a clear wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (to_hit) begin
      err_q <= 1'b1;
    end else if (bus.err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign bus.mem_valid   = valid_q;
  assign bus.mem_sel     = sel_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = err_q;
  assign bus.if_done     = (state == GRANT_IF) & done;
  assign bus.dm_done     = (state == GRANT_DM) & done;
  assign bus.if_stall    = bus.if_req & ~bus.if_done;
  assign bus.dm_stall    = bus.dm_req & ~bus.dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner sequences and
// random traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int WL = 4;
  localparam int TO = 16;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .WAIT_LIMIT(WL),
    .TIMEOUT   (TO)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  // model: who owns the port, which grant cycle it is in (1-based),
  // how long IF has waited, last select, sticky error
  int   m_owner;
  int   m_gcyc;
  int   m_wait;
  logic m_sel;
  logic m_err;

  task automatic model_reset();
    m_owner = 0;
    m_gcyc  = 0;
    m_wait  = 0;
    m_sel   = 1'b0;
    m_err   = 1'b0;
  endtask

  function automatic logic [7:0] model_out(input logic ir, dr, mr);
    logic d;
    d = (m_owner != 0) && (mr || m_gcyc == TO);
    return {m_owner != 0, m_sel,
            m_owner == 1 && d, m_owner == 2 && d,
            ir && !(m_owner == 1 && d),
            dr && !(m_owner == 2 && d),
            m_owner != 0, m_err};
  endfunction

  task automatic model_step(input logic ir, dr, mr, ec);
    bit timed_out;
    bit fin;
    bit starved;
    int nw;
    timed_out = (m_owner != 0) && !mr && (m_gcyc == TO);
    fin       = (m_owner != 0) && (mr || m_gcyc == TO);
    starved   = GUARD && (m_wait >= WL);
    if (!ir)
      nw = 0;
    else if (m_owner == 1)
      nw = m_wait;
    else
      nw = (m_wait + 1 > WL) ? WL : m_wait + 1;
    if (m_owner != 0) begin
      if (fin) m_owner = 0;
      else m_gcyc++;
    end else if (dr && !(starved && ir)) begin
      m_owner = 2;
      m_gcyc  = 1;
      m_sel   = 1'b1;
    end else if (ir) begin
      m_owner = 1;
      m_gcyc  = 1;
      m_sel   = 1'b0;
      nw      = 0;
    end
    m_wait = nw;
    if (timed_out) m_err = 1'b1;
    else if (ec) m_err = 1'b0;
  endtask

  function automatic logic [7:0] dut_out();
    return {bus.mem_valid, bus.mem_sel, bus.if_done, bus.dm_done,
            bus.if_stall, bus.dm_stall, bus.busy, bus.timeout_err};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, dr, mr, ec);
    bus.if_req    = ir;
    bus.dm_req    = dr;
    bus.mem_ready = mr;
    bus.err_clr   = ec;
  endtask

  task automatic cyc(input logic ir, dr, mr, ec);
    @(negedge clk);
    drive(ir, dr, mr, ec);
    #1;
    check("model", 32'(dut_out()), 32'(model_out(ir, dr, mr)));
    model_step(ir, dr, mr, ec);
  endtask

  typedef struct {
    logic       ir;
    logic       dr;
    logic       mr;
    logic       ec;
    logic [5:0] exp;
  } vec_t;

  vec_t vt[13];

  initial begin
    int first_if;
    int done_at;
    int n;
    logic ir_r;
    logic dr_r;
    logic hang;

    // {valid, sel, if_done, dm_done, if_stall, dm_stall}
    vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b000010};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b100010};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b100010};
    vt[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'b101000};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b000011};
    vt[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 6'b110110};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b010010};
    vt[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'b101000};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b000001};
    vt[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b110001};
    vt[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'b110100};
    vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b010000};

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #2;
    check("reset_valid", 32'(bus.mem_valid), 32'd0);
    check("reset_sel", 32'(bus.mem_sel), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_err", 32'(bus.timeout_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // IF access, simultaneous requests, DM stall
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vt[i].ir, vt[i].dr, vt[i].mr, vt[i].ec);
      #1;
      check($sformatf("vec%0d", i), 32'(dut_out() >> 2), 32'(vt[i].exp));
      model_step(vt[i].ir, vt[i].dr, vt[i].mr, vt[i].ec);
    end

    // starvation: DM re-requests with 1-cycle accesses
    first_if = -1;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      if (bus.mem_valid && !bus.mem_sel && first_if < 0) first_if = i;
    end
    check("starve_first_if", 32'(first_if), GUARD ? 32'd5 : 32'hffffffff);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // timeout without ready
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    done_at = -1;
    n = 0;
    while (n < 40 && done_at < 0) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      n++;
      if (bus.dm_done) done_at = n;
    end
    check("timeout_cycle", 32'(done_at), 32'd16);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("timeout_err_set", 32'(bus.timeout_err), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("timeout_err_clr", 32'(bus.timeout_err), 32'd0);

    // ready arrives in the last allowed cycle
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= TO; i++) cyc(1'b0, 1'b1, i == TO, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("late_ready_no_err", 32'(bus.timeout_err), 32'd0);
    check("late_ready_idle", 32'(bus.mem_valid), 32'd0);

    // reset in the middle of a DM access
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_valid", 32'(bus.mem_valid), 32'd0);
    check("midreset_sel", 32'(bus.mem_sel), 32'd0);
    check("midreset_done", 32'(bus.dm_done), 32'd0);
    check("midreset_busy", 32'(bus.busy), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // random traffic
    ir_r = 1'b0;
    dr_r = 1'b0;
    hang = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!ir_r) ir_r = $urandom_range(0, 1) == 0;
      else if ($urandom_range(0, 7) == 0) ir_r = 1'b0;
      if (!dr_r) dr_r = $urandom_range(0, 1) == 0;
      else if ($urandom_range(0, 7) == 0) dr_r = 1'b0;
      if ($urandom_range(0, 59) == 0) hang = ~hang;
      cyc(ir_r, dr_r, !hang && $urandom_range(0, 9) < 4,
          $urandom_range(0, 15) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the CPU's single memory port between instruction fetch (IF) and data memory (DM) stages. Holds the select for the address/write-data 2:1 muxes for the full length of a transaction, runs the port handshake, and raises per-stage stall signals to the pipeline. Sits between the IF/MEM stage logic and the unified memory model, driving the `sel` input of the port mux bank.

## Interface
- `WAIT_LIMIT`, 4: cycles a pending IF request may be bypassed before it gets priority; minimum 1.
- `TIMEOUT`, 16: maximum grant cycles without `mem_ready` before abort; minimum 2.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: IF requests the port; held until `if_done`.
- `dm_req` in 1: DM requests the port; held until `dm_done`.
- `mem_ready` in 1: memory completes the current access this cycle.
- `err_clr` in 1: clears sticky `timeout_err`.
- `mem_sel` out 1: port mux select; 0 = IF, 1 = DM.
- `mem_valid` out 1: access in progress on the port.
- `if_done`, `dm_done` out 1: one-cycle completion pulses.
- `if_stall`, `dm_stall` out 1: pipeline stall requests.
- `busy` out 1: the port is granted (`mem_valid` mirror for the hazard unit).
- `timeout_err` out 1: sticky abort flag.

## Operation
- FSM states: IDLE, GRANT_IF, GRANT_DM; 2-bit state register.
- IDLE: `dm_req` → GRANT_DM, unless the starve guard is active and `if_req`=1 → GRANT_IF; else `if_req` → GRANT_IF; else stay.
- GRANT_x: `mem_valid`=1, `mem_sel` = 1 for DM, 0 for IF. On `mem_ready`=1, `x_done`=1 (combinational, same cycle) → IDLE.
- Every transaction is followed by one IDLE turnaround cycle; there is no back-to-back grant.
- Requester drops `req` on the edge where `done` is high, or keeps it high to queue another access.
- `mem_sel` holds its last value in IDLE (glitch-free mux select); reset value 0.
- `if_stall` = `if_req` & ~`if_done`; `dm_stall` = `dm_req` & ~`dm_done`.
- Timeout: a counter clears on grant entry and increments each grant cycle. If the TIMEOUT-th grant cycle has `mem_ready`=0, the block pulses `x_done`, returns to IDLE, and sets `timeout_err` on the next edge. If `mem_ready` arrives in that same cycle, the access completes normally with no error.
- `timeout_err` stays set until `err_clr`=1 at an edge. If a set and a clear occur on the same edge, set wins.
- A request that drops while not granted is dropped silently; there is no abort of a granted access by `req` deassertion.

## Timing
- Reset: state IDLE, `mem_valid`=0, `mem_sel`=0, `busy`=0, `timeout_err`=0, counters 0. Applies immediately on `reset_n` falling, including mid-transaction. Done and stall outputs follow their inputs.
- Grant latency: a request sampled in IDLE at edge N gives `mem_valid`=1 from cycle N+1.
- A memory access of k grant cycles (`mem_ready` in the k-th) gives done in that cycle, with the state in IDLE from the next edge.
- Minimum request-to-request spacing on the port: grant cycles + 1 IDLE cycle.
- All FSM outputs are registered, except the done and stall outputs.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - Saturating wait counter of width $clog2(WAIT_LIMIT+1).
  - Increments each cycle `if_req`=1 and state ≠ GRANT_IF; clears on GRANT_IF entry or when `if_req`=0.
  - Guard is active when count ≥ WAIT_LIMIT; IF then wins IDLE arbitration over DM.
- Undefined: strict DM priority; IF can starve indefinitely. No counter logic is present.

## Test plan
- Reset mid-access: `dm_req`=1, granted, `mem_ready`=0 for 3 cycles, pull `reset_n` low → `mem_valid`=0, `mem_sel`=0 immediately; no `dm_done`.
- Single IF access: `if_req`=1 at edge 0, `mem_ready`=1 in the 3rd grant cycle → `mem_valid` high for cycles 1–3, `mem_sel`=0, `if_done` pulse in cycle 3, IDLE in cycle 4.
- Simultaneous requests: `if_req`=`dm_req`=1, `mem_ready`=1 each grant cycle → DM granted first (`mem_sel`=1), IDLE, then IF.
- Starvation, WAIT_LIMIT=4, guard on: `if_req` held, `dm_req` re-asserted continuously with 1-cycle accesses → IF granted once its wait count reaches 4, before the next DM grant. Guard off: IF is never granted while `dm_req`=1.
- Timeout, TIMEOUT=16: DM granted, `mem_ready`=0 → `dm_done` in grant cycle 16, `timeout_err`=1 from the next cycle; `err_clr` pulse → 0. Repeat with `mem_ready`=1 in cycle 16 → no error.
- Stall: `dm_req`=1 with 2-cycle access → `dm_stall`=1 in the IDLE request cycle and the first grant cycle, 0 in the `dm_done` cycle.
